// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier.
// State encoding and iteration count used by mul32_seq.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_t;

    localparam int MUL_ITER  = 32;
    localparam int MUL_CNT_W = 6;

endpackage

// File: rtl/mul32_seq_if.sv
// Operand/result handshake bundle for mul32_seq.
// The slave side is the multiplier, the master side is the ALU.
interface mul32_seq_if;

    logic         in_valid;
    logic         in_ready;
    logic [32:1]  A;
    logic [32:1]  B;
    logic         out_valid;
    logic         out_ready;
    logic [64:1]  P;

    modport master (
        output in_valid,
        output A,
        output B,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  P
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  out_ready,
        output in_ready,
        output out_valid,
        output P
    );

endinterface

// File: rtl/adder32.sv
// Combinational 32-bit adder with carry-out.
// Sole arithmetic element of the multiplier datapath.
module adder32 (
    input  logic [32:1] a,
    input  logic [32:1] b,
    output logic [32:1] s,
    output logic        c
);

    assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul32_seq.sv
// Sequential 32x32->64 unsigned shift-add multiplier.
// One adder32 iteration per cycle; handshakes on both sides.
module mul32_seq
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mul32_seq_if.slave  bus
);

    localparam logic [MUL_CNT_W:1] LAST = MUL_CNT_W'(MUL_ITER - 1);

    mul_state_t state;
    mul_state_t nstate;

    logic [32:1]        acc;
    logic [32:1]        mq;
    logic [32:1]        mcand;
    logic [MUL_CNT_W:1] cnt;

    logic [32:1] addend;
    logic [32:1] s;
    logic        c;
    logic        zero_op;

    assign zero_op = (bus.A == '0) || (bus.B == '0);
    assign addend  = mq[1] ? mcand : '0;

    adder32 u_add (
        .a (acc),
        .b (addend),
        .s (s),
        .c (c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MUL_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            MUL_IDLE: begin
                if (bus.in_valid) begin
                    nstate = zero_op ? MUL_DONE : MUL_RUN;
                end
            end
            MUL_RUN: begin
                if (cnt == LAST) begin
                    nstate = MUL_DONE;
                end
            end
            MUL_DONE: begin
                if (bus.out_ready) begin
                    nstate = MUL_IDLE;
                end
            end
            default: nstate = MUL_IDLE;
        endcase
    end

    // Carry re-enters at the top of acc so no product bit is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mq    <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (bus.in_valid) begin
                        mcand <= bus.A;
                        mq    <= zero_op ? '0 : bus.B;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                MUL_RUN: begin
                    acc <= {c, s[32:2]};
                    mq  <= {s[1], mq[32:2]};
                    cnt <= cnt + MUL_CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == MUL_IDLE);
    assign bus.out_valid = (state == MUL_DONE);
    assign bus.P         = {acc, mq};

endmodule
